ctrl_packet_initiator: RTL and testbench
========================================

CTRL_PACKET_INITIATOR -- requirements
Module: ctrl_packet_initiator

Interface
REQ-001 Parameters SHALL be DATA_WIDTH=512, multiple of 32; STREAM_ID_NUM=16; CHUNK_ID_NUM=32; CHANNEL_ID_NUM=1024; STATE_WIDTH=32; CTRL_STREAM_ID=0, the StreamID stamped on emitted packets; TIMEOUT_CYCLES=1024, read-response wait limit, minimum 2.
REQ-002 Derived widths SHALL be SIDW=clog2(STREAM_ID_NUM), CKW=clog2(CHUNK_ID_NUM), CHW=clog2(CHANNEL_ID_NUM), NF=DATA_WIDTH/32.
REQ-003 Ports, listed as name  direction  width  meaning:
  clk  in  1  single clock, rising edge.
  rst  in  1  asynchronous, active-high reset.
  cmd_valid  in  1  host command present.
  cmd_ready  out  1  block can accept a command.
  cmd_write  in  1  1=CTRL_WRITE_32b, 0=CTRL_READ_REQUEST_32b.
  cmd_hop  in  CHW  target hop count; 0 = first downstream module.
  cmd_addr  in  STATE_WIDTH  control register address.
  cmd_wdata  in  32  write value.
  rsp_valid  out  1  one-cycle completion pulse.
  rsp_rdata  out  32  read data, 0 for writes and errors.
  rsp_error  out  1  read timed out; qualified by rsp_valid.
  tx_Data / tx_Type[1:0] / tx_Last / tx_StreamID[SIDW] / tx_ChunkID[CKW] / tx_ChannelID[CHW] / tx_State[STATE_WIDTH]  out  forward-path packet.
  rx_Data / rx_Type[1:0] / rx_ChunkID[CKW] / rx_State[STATE_WIDTH]  in  return-path packet.

Function
REQ-004 Type encoding SHALL be bit1 = control packet valid and bit0 = data packet valid; idle tx_Type SHALL be 2'b00.
REQ-005 FSM states SHALL be IDLE, WAIT, RESP.
REQ-006 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge with cmd_valid & cmd_ready.
REQ-007 In the cycle after acceptance, tx SHALL present exactly one packet, all outputs registered:
  - tx_Type=2'b10, tx_Last=1, tx_StreamID=CTRL_STREAM_ID.
  - tx_ChunkID={1'b1, code}, where code=1 for write and 0 for read.
  - tx_ChannelID=cmd_hop, tx_State=cmd_addr.
  - tx_Data=cmd_wdata replicated NF times for a write, all zeros for a read.
REQ-008 tx_Type SHALL return to 2'b00 on the following cycle; other tx fields hold their last values.
REQ-009 Write command SHALL go IDLE->RESP; rsp_valid=1 with rsp_rdata=0 and rsp_error=0 in the same cycle as the tx packet; the FSM then returns to IDLE.
REQ-010 Read command SHALL go IDLE->WAIT, latching cmd_addr as pend_addr and clearing a timeout counter.
REQ-011 In WAIT, a match SHALL be rx_Type[1]=1 & rx_ChunkID[CKW-1]=0 & rx_ChunkID[CKW-2:0]=1 (CP_A_CTRL_READ_RESPONSE_32b) & rx_State==pend_addr.
REQ-012 On a match, the next cycle SHALL give rsp_valid=1, rsp_rdata=rx_Data[31:0], rsp_error=0.
REQ-013 Non-matching rx packets, including data packets and rx_Type=2'b11 without a match, SHALL be ignored in every state.
REQ-014 Counter SHALL increment each WAIT cycle without a match; on reaching TIMEOUT_CYCLES-1 the next cycle SHALL give rsp_valid=1, rsp_error=1, rsp_rdata=0.
REQ-015 A match in the same cycle as timeout expiry SHALL win; the response is success.
REQ-016 rsp_valid SHALL be a single-cycle pulse; RESP lasts one cycle and returns to IDLE.
REQ-017 A matching response arriving in IDLE or RESP SHALL be dropped.
REQ-018 Commands back-to-back: the next command is accepted no earlier than the cycle after the rsp_valid pulse.
REQ-019 Counter width SHALL be clog2(TIMEOUT_CYCLES); it SHALL saturate and never wrap.

Reset
REQ-020 rst SHALL asynchronously force IDLE, tx_Type=0, rsp_valid=0, rsp_error=0, rsp_rdata=0, and counter=0; the other tx fields and pend_addr reset to 0.
REQ-021 rst asserted mid-WAIT SHALL abandon the transaction with no rsp_valid; cmd_ready=1 in the first cycle after rst deasserts.

Structure
REQ-022 The shared package SHALL hold the Type bit positions, the CP_A_* and CP_R_* codes, the INSTRUCTION_CMD_* codes, and the FSM state enum.
REQ-023 The block SHALL be single-level with no sub-module; the FSM, counter and tx register live in one module.

Verification
REQ-024 Write, hop=3, addr=0x10, wdata=0xDEADBEEF -> next cycle tx_Type=2'b10, ChunkID=0x11, ChannelID=3, State=0x10, every 32-bit field of tx_Data=0xDEADBEEF; rsp_valid=1 with rsp_error=0 in the same cycle.
REQ-025 Read, hop=0, addr=0x20; response on cycle 5 with ChunkID=0x01, State=0x20, Data[31:0]=0x12345678 -> rsp_valid on cycle 6 with rdata=0x12345678 and error=0.
REQ-026 Read, addr=0x20; rx delivers a data packet, then a response with State=0x24, and no match -> ignored; rsp_error=1 exactly TIMEOUT_CYCLES cycles after entering WAIT.
REQ-027 Match presented in the expiry cycle -> rsp_error=0 and rdata is taken from rx.
REQ-028 rst pulsed in the middle of WAIT -> outputs are zero immediately, no rsp_valid, cmd_ready=1 after release; a later response with State=0x20 is dropped.
REQ-029 cmd_valid held high for 3 writes -> exactly 3 tx packets, each 2 cycles apart, and 3 rsp_valid pulses.

Source files
------------

// File: rtl/ctrl_packet_initiator_pkg.sv
// Shared encodings for the control-packet initiator: packet Type bits, ChunkID codes,
// host command codes and the FSM state type.
package ctrl_packet_initiator_pkg;

    localparam int TYPE_DATA_BIT = 0;
    localparam int TYPE_CTRL_BIT = 1;

    localparam logic [1:0] TYPE_IDLE = 2'b00;
    localparam logic [1:0] TYPE_CTRL = 2'b10;

    // ChunkID MSB gives the direction (request vs answer); the lower bits carry the code.
    localparam logic CHUNK_DIR_REQUEST = 1'b1;
    localparam logic CHUNK_DIR_ANSWER  = 1'b0;

    localparam int CP_R_CTRL_READ_REQUEST_32b  = 0;
    localparam int CP_R_CTRL_WRITE_32b         = 1;
    localparam int CP_A_CTRL_READ_RESPONSE_32b = 1;

    localparam logic INSTRUCTION_CMD_READ  = 1'b0;
    localparam logic INSTRUCTION_CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic is_ctrl_packet(input logic [1:0] pkt_type);
        return pkt_type[TYPE_CTRL_BIT];
    endfunction

endpackage

// File: rtl/ctrl_packet_initiator_if.sv
// Host command/response handshake plus forward (tx) and return (rx) packet buses of the
// control-packet initiator. The slave modport is the initiator's view.
interface ctrl_packet_initiator_if #(
    parameter int DATA_WIDTH     = 512,
    parameter int STREAM_ID_NUM  = 16,
    parameter int CHUNK_ID_NUM   = 32,
    parameter int CHANNEL_ID_NUM = 1024,
    parameter int STATE_WIDTH    = 32
);
    localparam int SIDW = $clog2(STREAM_ID_NUM);
    localparam int CKW  = $clog2(CHUNK_ID_NUM);
    localparam int CHW  = $clog2(CHANNEL_ID_NUM);

    logic                   cmd_valid;
    logic                   cmd_ready;
    logic                   cmd_write;
    logic [CHW-1:0]         cmd_hop;
    logic [STATE_WIDTH-1:0] cmd_addr;
    logic [31:0]            cmd_wdata;

    logic                   rsp_valid;
    logic [31:0]            rsp_rdata;
    logic                   rsp_error;

    logic [DATA_WIDTH-1:0]  tx_Data;
    logic [1:0]             tx_Type;
    logic                   tx_Last;
    logic [SIDW-1:0]        tx_StreamID;
    logic [CKW-1:0]         tx_ChunkID;
    logic [CHW-1:0]         tx_ChannelID;
    logic [STATE_WIDTH-1:0] tx_State;

    logic [DATA_WIDTH-1:0]  rx_Data;
    logic [1:0]             rx_Type;
    logic [CKW-1:0]         rx_ChunkID;
    logic [STATE_WIDTH-1:0] rx_State;

    modport slave (
        input  cmd_valid, cmd_write, cmd_hop, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_error,
        output tx_Data, tx_Type, tx_Last, tx_StreamID, tx_ChunkID, tx_ChannelID, tx_State,
        input  rx_Data, rx_Type, rx_ChunkID, rx_State
    );

    modport master (
        output cmd_valid, cmd_write, cmd_hop, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_error,
        input  tx_Data, tx_Type, tx_Last, tx_StreamID, tx_ChunkID, tx_ChannelID, tx_State,
        output rx_Data, rx_Type, rx_ChunkID, rx_State
    );

endinterface

// File: rtl/ctrl_packet_initiator.sv
// Turns host read/write commands into single-beat control packets on the forward path and
// waits (bounded by a timeout) for the matching read response on the return path.
module ctrl_packet_initiator
    import ctrl_packet_initiator_pkg::*;
#(
    parameter int DATA_WIDTH     = 512,
    parameter int STREAM_ID_NUM  = 16,
    parameter int CHUNK_ID_NUM   = 32,
    parameter int CHANNEL_ID_NUM = 1024,
    parameter int STATE_WIDTH    = 32,
    parameter int CTRL_STREAM_ID = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    ctrl_packet_initiator_if.slave bus
);

    localparam int SIDW = $clog2(STREAM_ID_NUM);
    localparam int CKW  = $clog2(CHUNK_ID_NUM);
    localparam int CHW  = $clog2(CHANNEL_ID_NUM);
    localparam int NF   = DATA_WIDTH / 32;
    localparam int CNTW = $clog2(TIMEOUT_CYCLES);

    localparam logic [SIDW-1:0] STREAM_ID     = SIDW'(CTRL_STREAM_ID);
    localparam logic [CKW-2:0]  CODE_READ     = CP_R_CTRL_READ_REQUEST_32b[CKW-2:0];
    localparam logic [CKW-2:0]  CODE_WRITE    = CP_R_CTRL_WRITE_32b[CKW-2:0];
    localparam logic [CKW-2:0]  CODE_RESPONSE = CP_A_CTRL_READ_RESPONSE_32b[CKW-2:0];
    localparam logic [CNTW-1:0] CNT_LAST      = CNTW'(TIMEOUT_CYCLES - 1);
    localparam logic [CNTW-1:0] CNT_MAX       = '1;

    state_e                 state_q, state_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;
    logic [STATE_WIDTH-1:0] pend_addr_q, pend_addr_d;

    logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
    logic [1:0]             tx_type_q, tx_type_d;
    logic                   tx_last_q, tx_last_d;
    logic [SIDW-1:0]        tx_stream_id_q, tx_stream_id_d;
    logic [CKW-1:0]         tx_chunk_id_q, tx_chunk_id_d;
    logic [CHW-1:0]         tx_channel_id_q, tx_channel_id_d;
    logic [STATE_WIDTH-1:0] tx_state_q, tx_state_d;

    logic                   rsp_valid_q, rsp_valid_d;
    logic [31:0]            rsp_rdata_q, rsp_rdata_d;
    logic                   rsp_error_q, rsp_error_d;

    logic                   rsp_match;
    logic                   unused_rx;

    // Only the read-response answer for the outstanding address counts; everything else
    // on the return path (data packets, other codes, other addresses) passes by unnoticed.
    assign rsp_match = is_ctrl_packet(bus.rx_Type)
                     && (bus.rx_ChunkID[CKW-1] == CHUNK_DIR_ANSWER)
                     && (bus.rx_ChunkID[CKW-2:0] == CODE_RESPONSE)
                     && (bus.rx_State == pend_addr_q);

    assign unused_rx = ^{bus.rx_Data[DATA_WIDTH-1:32], bus.rx_Type[TYPE_DATA_BIT]};

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        pend_addr_d     = pend_addr_q;
        tx_data_d       = tx_data_q;
        tx_type_d       = TYPE_IDLE;
        tx_last_d       = tx_last_q;
        tx_stream_id_d  = tx_stream_id_q;
        tx_chunk_id_d   = tx_chunk_id_q;
        tx_channel_id_d = tx_channel_id_q;
        tx_state_d      = tx_state_q;
        rsp_valid_d     = 1'b0;
        rsp_rdata_d     = '0;
        rsp_error_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    tx_type_d       = TYPE_CTRL;
                    tx_last_d       = 1'b1;
                    tx_stream_id_d  = STREAM_ID;
                    tx_channel_id_d = bus.cmd_hop;
                    tx_state_d      = bus.cmd_addr;
                    case (bus.cmd_write)
                        INSTRUCTION_CMD_WRITE: begin
                            tx_chunk_id_d = {CHUNK_DIR_REQUEST, CODE_WRITE};
                            tx_data_d     = {NF{bus.cmd_wdata}};
                            state_d       = ST_RESP;
                            rsp_valid_d   = 1'b1;
                        end
                        default: begin
                            tx_chunk_id_d = {CHUNK_DIR_REQUEST, CODE_READ};
                            tx_data_d     = '0;
                            state_d       = ST_WAIT;
                            pend_addr_d   = bus.cmd_addr;
                            cnt_d         = '0;
                        end
                    endcase
                end
            end

            // A response arriving on the expiry cycle still wins over the timeout.
            ST_WAIT: begin
                if (rsp_match) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = bus.rx_Data[31:0];
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_error_d = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            pend_addr_q     <= '0;
            tx_data_q       <= '0;
            tx_type_q       <= TYPE_IDLE;
            tx_last_q       <= 1'b0;
            tx_stream_id_q  <= '0;
            tx_chunk_id_q   <= '0;
            tx_channel_id_q <= '0;
            tx_state_q      <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_error_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            pend_addr_q     <= pend_addr_d;
            tx_data_q       <= tx_data_d;
            tx_type_q       <= tx_type_d;
            tx_last_q       <= tx_last_d;
            tx_stream_id_q  <= tx_stream_id_d;
            tx_chunk_id_q   <= tx_chunk_id_d;
            tx_channel_id_q <= tx_channel_id_d;
            tx_state_q      <= tx_state_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_error_q     <= rsp_error_d;
        end
    end

    assign bus.cmd_ready    = (state_q == ST_IDLE);
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.rsp_error    = rsp_error_q;
    assign bus.tx_Data      = tx_data_q;
    assign bus.tx_Type      = tx_type_q;
    assign bus.tx_Last      = tx_last_q;
    assign bus.tx_StreamID  = tx_stream_id_q;
    assign bus.tx_ChunkID   = tx_chunk_id_q;
    assign bus.tx_ChannelID = tx_channel_id_q;
    assign bus.tx_State     = tx_state_q;

endmodule

// File: tb/tb_ctrl_packet_initiator.sv
// Self-checking bench for ctrl_packet_initiator: directed vector table, hand-written
// reset/back-to-back sequences and randomized transactions against a transaction-level model.
module tb_ctrl_packet_initiator;

    localparam int DW      = 512;
    localparam int SW      = 32;
    localparam int CKW     = 5;
    localparam int CHW     = 10;
    localparam int SIDW    = 4;
    localparam int NF      = DW / 32;
    localparam int TIMEOUT = 1024;
    localparam int STREAM  = 0;

    typedef struct {
        logic            write;
        logic [CHW-1:0]  hop;
        logic [SW-1:0]   addr;
        logic [31:0]     wdata;
        int              match_at;
        logic [31:0]     rx_word;
        logic            noise;
        int              exp_rsp_cycle;
        logic            exp_error;
        logic [31:0]     exp_rdata;
    } txn_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    ctrl_packet_initiator_if #(
        .DATA_WIDTH(DW), .STREAM_ID_NUM(16), .CHUNK_ID_NUM(32),
        .CHANNEL_ID_NUM(1024), .STATE_WIDTH(SW)
    ) bus ();

    ctrl_packet_initiator #(
        .DATA_WIDTH(DW), .STREAM_ID_NUM(16), .CHUNK_ID_NUM(32), .CHANNEL_ID_NUM(1024),
        .STATE_WIDTH(SW), .CTRL_STREAM_ID(STREAM), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string what, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h want=%0h", what, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic write, input logic [CHW-1:0] hop,
                                 input logic [SW-1:0] addr, input logic [31:0] wdata);
        bus.cmd_valid = valid;
        bus.cmd_write = write;
        bus.cmd_hop   = hop;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] random_data();
        logic [DW-1:0] d;
        for (int f = 0; f < NF; f++) d[f*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic drive_rx_idle();
        bus.rx_Data    = '0;
        bus.rx_Type    = 2'b00;
        bus.rx_ChunkID = '0;
        bus.rx_State   = '0;
    endtask

    task automatic drive_rx_match(input logic [SW-1:0] addr, input logic [31:0] word);
        logic [DW-1:0] d;
        d = random_data();
        d[31:0] = word;
        bus.rx_Data    = d;
        bus.rx_Type    = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
        bus.rx_ChunkID = CKW'(1);
        bus.rx_State   = addr;
    endtask

    // Packets that look close to a valid answer but each break exactly one match rule.
    task automatic drive_rx_noise(input logic [SW-1:0] addr, input int kind);
        bus.rx_Data = random_data();
        case (kind)
            0: begin bus.rx_Type = 2'b01; bus.rx_ChunkID = CKW'(1);     bus.rx_State = addr;          end
            1: begin bus.rx_Type = 2'b11; bus.rx_ChunkID = CKW'(1);     bus.rx_State = addr ^ 32'h4;  end
            2: begin bus.rx_Type = 2'b10; bus.rx_ChunkID = CKW'(5'h11); bus.rx_State = addr;          end
            default: begin bus.rx_Type = 2'b10; bus.rx_ChunkID = CKW'(2); bus.rx_State = addr;       end
        endcase
    endtask

    function automatic txn_t make_txn(input logic write, input logic [CHW-1:0] hop,
                                      input logic [SW-1:0] addr, input logic [31:0] wdata,
                                      input int match_at, input logic [31:0] rx_word,
                                      input logic noise, input int exp_cycle,
                                      input logic exp_error, input logic [31:0] exp_rdata);
        txn_t t;
        t.write = write; t.hop = hop; t.addr = addr; t.wdata = wdata;
        t.match_at = match_at; t.rx_word = rx_word; t.noise = noise;
        t.exp_rsp_cycle = exp_cycle; t.exp_error = exp_error; t.exp_rdata = exp_rdata;
        return t;
    endfunction

    // Cycle index 0 is the cycle that shows the tx packet; a read answer seen in cycle m
    // completes in cycle m+1, otherwise the timeout completes TIMEOUT cycles in.
    function automatic txn_t model_expect(input txn_t t);
        txn_t r;
        r = t;
        if (t.write) begin
            r.exp_rsp_cycle = 0; r.exp_error = 1'b0; r.exp_rdata = '0;
        end else if (t.match_at >= 0 && t.match_at < TIMEOUT) begin
            r.exp_rsp_cycle = t.match_at + 1; r.exp_error = 1'b0; r.exp_rdata = t.rx_word;
        end else begin
            r.exp_rsp_cycle = TIMEOUT; r.exp_error = 1'b1; r.exp_rdata = '0;
        end
        return r;
    endfunction

    task automatic run_txn(input txn_t t);
        logic [DW-1:0]  exp_data;
        logic [CKW-1:0] exp_chunk;
        for (int f = 0; f < NF; f++) exp_data[f*32 +: 32] = t.write ? t.wdata : 32'h0;
        exp_chunk = t.write ? CKW'(5'h11) : CKW'(5'h10);

        applyStimulus(1'b1, t.write, t.hop, t.addr, t.wdata);
        checkOutput("cmd_ready_idle", bus.cmd_ready, 1);
        step();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);

        checkOutput("tx_type_pkt", bus.tx_Type, 2'b10);
        checkOutput("tx_last", bus.tx_Last, 1);
        checkOutput("tx_stream", bus.tx_StreamID, SIDW'(STREAM));
        checkOutput("tx_chunk", bus.tx_ChunkID, exp_chunk);
        checkOutput("tx_channel", bus.tx_ChannelID, t.hop);
        checkOutput("tx_state", bus.tx_State, t.addr);
        checkOutput("tx_data", bus.tx_Data, exp_data);

        for (int c = 0; c < t.exp_rsp_cycle; c++) begin
            if (c > 0) checkOutput("tx_type_idle", bus.tx_Type, 2'b00);
            checkOutput("rsp_valid_early", bus.rsp_valid, 0);
            checkOutput("cmd_ready_busy", bus.cmd_ready, 0);
            if (c == t.match_at) drive_rx_match(t.addr, t.rx_word);
            else if (t.noise) drive_rx_noise(t.addr, c % 4);
            else drive_rx_idle();
            step();
        end

        checkOutput("rsp_valid", bus.rsp_valid, 1);
        checkOutput("rsp_error", bus.rsp_error, t.exp_error);
        checkOutput("rsp_rdata", bus.rsp_rdata, t.exp_rdata);
        checkOutput("cmd_ready_resp", bus.cmd_ready, 0);
        if (t.exp_rsp_cycle > 0) checkOutput("tx_type_resp", bus.tx_Type, 2'b00);

        drive_rx_match(t.addr, $urandom);
        step();
        checkOutput("rsp_pulse_end", bus.rsp_valid, 0);
        checkOutput("rsp_error_end", bus.rsp_error, 0);
        checkOutput("cmd_ready_after", bus.cmd_ready, 1);
        checkOutput("tx_type_after", bus.tx_Type, 2'b00);
        checkOutput("tx_state_hold", bus.tx_State, t.addr);
        checkOutput("tx_channel_hold", bus.tx_ChannelID, t.hop);
    endtask

    initial begin
        txn_t vecs[7];
        txn_t t;
        int   pkts;
        int   pulses;
        logic [31:0] wd;

        total = 0;
        bad   = 0;
        rst   = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        drive_rx_idle();

        vecs[0] = make_txn(1'b1, 10'd3,    32'h10,       32'hDEADBEEF, -1,      32'h0,        1'b0, 0,       1'b0, 32'h0);
        vecs[1] = make_txn(1'b0, 10'd0,    32'h20,       32'h0,        4,       32'h12345678, 1'b0, 5,       1'b0, 32'h12345678);
        vecs[2] = make_txn(1'b0, 10'd0,    32'h20,       32'h0,        -1,      32'h0,        1'b1, TIMEOUT, 1'b1, 32'h0);
        vecs[3] = make_txn(1'b0, 10'd7,    32'h20,       32'h0,        TIMEOUT-1, 32'hCAFEF00D, 1'b1, TIMEOUT, 1'b0, 32'hCAFEF00D);
        vecs[4] = make_txn(1'b0, 10'd1023, 32'hFFFFFFFC, 32'h0,        0,       32'h0000A5A5, 1'b0, 1,       1'b0, 32'h0000A5A5);
        vecs[5] = make_txn(1'b1, 10'd1023, 32'hFFFFFFFF, 32'h0,        -1,      32'h0,        1'b0, 0,       1'b0, 32'h0);
        vecs[6] = make_txn(1'b0, 10'd5,    32'h24,       32'h0,        2,       32'h0,        1'b1, 3,       1'b0, 32'h0);

        #2 rst = 1'b1;
        #1;
        checkOutput("reset_tx_type", bus.tx_Type, 2'b00);
        checkOutput("reset_tx_last", bus.tx_Last, 0);
        checkOutput("reset_tx_stream", bus.tx_StreamID, 0);
        checkOutput("reset_tx_chunk", bus.tx_ChunkID, 0);
        checkOutput("reset_tx_channel", bus.tx_ChannelID, 0);
        checkOutput("reset_tx_state", bus.tx_State, 0);
        checkOutput("reset_tx_data", bus.tx_Data, 0);
        checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
        checkOutput("reset_rsp_rdata", bus.rsp_rdata, 0);
        checkOutput("reset_rsp_error", bus.rsp_error, 0);
        checkOutput("reset_cmd_ready", bus.cmd_ready, 1);
        step();
        step();
        #2 rst = 1'b0;

        for (int i = 0; i < 7; i++) run_txn(vecs[i]);

        // cmd_valid held high: commands land every other cycle, three packets and pulses.
        pkts   = 0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            wd = 32'hA0000000 + 32'(k);
            applyStimulus(1'b1, 1'b1, CHW'(k), 32'h100 + 32'(k), wd);
            step();
            if (bus.tx_Type == 2'b10) pkts++;
            if (bus.rsp_valid) pulses++;
            if (k % 2 == 0) begin
                checkOutput("b2b_tx_type", bus.tx_Type, 2'b10);
                checkOutput("b2b_tx_data", bus.tx_Data[31:0], wd);
                checkOutput("b2b_rsp_valid", bus.rsp_valid, 1);
            end else begin
                checkOutput("b2b_tx_gap", bus.tx_Type, 2'b00);
                checkOutput("b2b_rsp_gap", bus.rsp_valid, 0);
            end
        end
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        step();
        if (bus.tx_Type == 2'b10) pkts++;
        if (bus.rsp_valid) pulses++;
        checkOutput("b2b_packets", pkts, 3);
        checkOutput("b2b_pulses", pulses, 3);

        for (int n = 0; n < 24; n++) begin
            int r;
            t.write   = $urandom_range(0, 1) == 1;
            t.hop     = CHW'($urandom);
            t.addr    = $urandom;
            t.wdata   = $urandom;
            t.rx_word = $urandom;
            t.noise   = $urandom_range(0, 1) == 1;
            r = $urandom_range(0, 9);
            if (r == 0) t.match_at = -1;
            else if (r == 1) t.match_at = TIMEOUT - 1;
            else t.match_at = $urandom_range(0, 15);
            run_txn(model_expect(t));
        end

        // Reset in the middle of a read: abandon it, and a late answer must not complete it.
        applyStimulus(1'b1, 1'b0, 10'd0, 32'h20, 32'h0);
        drive_rx_idle();
        step();
        applyStimulus(1'b0, 1'b0, '0, '0, '0);
        step();
        step();
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_tx_type", bus.tx_Type, 2'b00);
        checkOutput("midrst_tx_state", bus.tx_State, 0);
        checkOutput("midrst_rsp_valid", bus.rsp_valid, 0);
        checkOutput("midrst_rsp_rdata", bus.rsp_rdata, 0);
        checkOutput("midrst_cmd_ready", bus.cmd_ready, 1);
        @(posedge clk);
        #3 rst = 1'b0;
        checkOutput("midrst_ready_release", bus.cmd_ready, 1);
        for (int k = 0; k < 4; k++) begin
            drive_rx_match(32'h20, 32'hBAD0BAD0);
            step();
            checkOutput("midrst_late_rsp", bus.rsp_valid, 0);
            checkOutput("midrst_ready_hold", bus.cmd_ready, 1);
        end
        drive_rx_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
